// File: rtl/key_filter_pkg.sv
// Shared definitions for the key debouncer: FSM encoding and 50 MHz / 20 ms defaults.
package key_filter_pkg;

  localparam int unsigned CNT_W_DEF   = 20;
  localparam logic [19:0] CNT_MAX_DEF = 20'd1_000_000;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILTER_DOWN = 2'd1,
    DOWN        = 2'd2,
    FILTER_UP   = 2'd3
  } state_t;

endpackage

// File: rtl/key_filter_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reset value is selectable.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_filter.sv
// Debounces an active-low key: clean level plus one-cycle press/release pulses
// once the synchronized level has held for CNT_MAX cycles.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MAX_DEF)
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_out,
  output logic key_press_flag,
  output logic key_release_flag
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);

  logic             key_sync;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             key_out_nxt, press_nxt, release_nxt;

  // Idle level of the key is released (1), so the synchronizer resets high.
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (key_in),
    .q     (key_sync)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      key_out          <= 1'b1;
      key_press_flag   <= 1'b0;
      key_release_flag <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      key_out          <= key_out_nxt;
      key_press_flag   <= press_nxt;
      key_release_flag <= release_nxt;
    end
  end

  // Any opposite sample while filtering falls back to the stable state with no credit kept.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    key_out_nxt = key_out;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!key_sync) state_nxt = FILTER_DOWN;
      end
      FILTER_DOWN: begin
        if (key_sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = DOWN;
          cnt_nxt     = '0;
          key_out_nxt = 1'b0;
          press_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DOWN: begin
        cnt_nxt = '0;
        if (key_sync) state_nxt = FILTER_UP;
      end
      FILTER_UP: begin
        if (!key_sync) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          key_out_nxt = 1'b1;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter with CNT_MAX = 10: directed timing checks plus random stimulus
// compared every cycle against a run-length model of the debouncer.
module tb_key_filter;

  localparam int CNT_MAX = 10;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_in    = 1'b0;
  logic key_out;
  logic key_press_flag;
  logic key_release_flag;

  int errors = 0;
  int checks = 0;

  // Reference model: key_in reaches the filter two edges late; the level flips on the
  // (CNT_MAX+1)-th consecutive sample that disagrees with it.
  logic m_s1 = 1'b1;
  logic m_ks = 1'b1;
  logic m_level = 1'b1;
  logic m_press = 1'b0;
  logic m_release = 1'b0;
  int   m_run = 0;

  key_filter #(
    .CNT_W   (20),
    .CNT_MAX (20'd10)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .key_in           (key_in),
    .key_out          (key_out),
    .key_press_flag   (key_press_flag),
    .key_release_flag (key_release_flag)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_s1 <= 1'b1; m_ks <= 1'b1; m_level <= 1'b1;
      m_run <= 0; m_press <= 1'b0; m_release <= 1'b0;
    end else begin
      m_s1      <= key_in;
      m_ks      <= m_s1;
      m_press   <= 1'b0;
      m_release <= 1'b0;
      if (m_ks != m_level) begin
        if (m_run == CNT_MAX) begin
          m_level   <= m_ks;
          m_press   <= !m_ks;
          m_release <= m_ks;
          m_run     <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    check("model_key_out", key_out, m_level);
    check("model_press", key_press_flag, m_press);
    check("model_release", key_release_flag, m_release);
  end

  // Change key_in just after an edge, so the next rising edge is the first to sample it.
  task automatic set_key(input logic v);
    @(posedge sys_clk);
    #1 key_in = v;
  endtask

  // Called right after key_in changes (or reset releases); the accepting edge is n edges
  // after the first sampling edge, e.g. n = 12 for CNT_MAX = 10.
  task automatic expect_edge(input logic press, input int n);
    repeat (n) @(posedge sys_clk);
    #1;
    check("pre_press", key_press_flag, 1'b0);
    check("pre_release", key_release_flag, 1'b0);
    check("pre_out", key_out, press);
    @(posedge sys_clk);
    #1;
    check("edge_press", key_press_flag, press);
    check("edge_release", key_release_flag, !press);
    check("edge_out", key_out, !press);
    @(posedge sys_clk);
    #1;
    check("post_press", key_press_flag, 1'b0);
    check("post_release", key_release_flag, 1'b0);
    check("post_out", key_out, !press);
  endtask

  initial begin
    int zrun;
    // Reset with the key already held down.
    @(posedge sys_clk);
    #1;
    check("rst_out", key_out, 1'b1);
    check("rst_press", key_press_flag, 1'b0);
    check("rst_release", key_release_flag, 1'b0);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    expect_edge(1'b1, 12);

    set_key(1'b1);
    expect_edge(1'b0, 12);

    set_key(1'b0);
    expect_edge(1'b1, 12);

    // Release glitched back to 0 on the terminal sample: abort, then restart.
    set_key(1'b1);
    repeat (9) @(posedge sys_clk);
    set_key(1'b0);
    set_key(1'b1);
    repeat (2) @(posedge sys_clk);
    #1;
    check("glitch_out", key_out, 1'b0);
    check("glitch_release", key_release_flag, 1'b0);
    expect_edge(1'b0, 10);

    // Bounce: 5 low samples, 1 high, then low steady.
    set_key(1'b0);
    repeat (4) @(posedge sys_clk);
    set_key(1'b1);
    set_key(1'b0);
    expect_edge(1'b1, 12);

    set_key(1'b1);
    expect_edge(1'b0, 12);

    // Reset while the press filter counter sits at 6.
    set_key(1'b0);
    repeat (9) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    repeat (2) begin
      @(posedge sys_clk);
      #1;
      check("midrst_out", key_out, 1'b1);
      check("midrst_press", key_press_flag, 1'b0);
    end
    sys_rst_n = 1'b1;
    expect_edge(1'b1, 12);

    set_key(1'b1);
    expect_edge(1'b0, 12);

    // Random chatter with low runs capped well below the filter length: nothing accepted.
    zrun = 0;
    for (int i = 0; i < 300; i++) begin
      logic b;
      b = 1'($urandom & 1);
      if (zrun >= 8) b = 1'b1;
      zrun = b ? 0 : zrun + 1;
      set_key(b);
      check("rnd_out", key_out, 1'b1);
      check("rnd_press", key_press_flag, 1'b0);
      check("rnd_release", key_release_flag, 1'b0);
    end

    // Random hold lengths straddling the filter length; the model judges every cycle.
    for (int i = 0; i < 80; i++) begin
      set_key(1'($urandom & 1));
      repeat ($urandom_range(0, 15)) @(posedge sys_clk);
    end
    set_key(1'b1);
    repeat (30) @(posedge sys_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
